// File: rtl/id_hazard_sched.sv
// Scoreboard hazard scheduler for the ID-stage branch comparator: stall, forwarding selects, branch strobe.
// Zero-latency combinational decisions; a stall holds ID and loads a bubble into E. Optional HAZARD_STALL_CNT_EN adds counters.
module id_hazard_sched #(
   parameter int REG_AW = 5,
   parameter int TNEW_W = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              id_valid,
   input  logic              id_is_branch,
   input  logic [2:0]        id_cmp_op,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [TNEW_W-1:0] id_rs_tuse,
   input  logic [TNEW_W-1:0] id_rt_tuse,
   input  logic              id_rs_used,
   input  logic              id_rt_used,
   input  logic              id_wr_en,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [TNEW_W-1:0] id_tnew,
   input  logic              cmp_out,
   output logic              stall,
   output logic [1:0]        fwd_sel_rs,
   output logic [1:0]        fwd_sel_rt,
   output logic [2:0]        cmp_op,
   output logic              branch_taken
`ifdef HAZARD_STALL_CNT_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       branch_cnt
`endif
);

   typedef struct packed {
      logic              vld;
      logic [REG_AW-1:0] rd;
      logic [TNEW_W-1:0] tnew;
   } slot_t;

   localparam logic [TNEW_W-1:0] TNEW_MAX = TNEW_W'(2);

   slot_t e_slot, m_slot, w_slot;

   function automatic logic [TNEW_W-1:0] dec_sat(input logic [TNEW_W-1:0] t);
      return (t == '0) ? '0 : t - TNEW_W'(1);
   endfunction

   // Returns {hazard, fwd_sel}; the youngest match decides the select, any unready match stalls.
   function automatic logic [2:0] resolve(input logic used, input logic [REG_AW-1:0] r,
                                          input logic [TNEW_W-1:0] tuse,
                                          input slot_t e, input slot_t m, input slot_t w);
      logic me, mm, mw, hz;
      logic [1:0] sel;
      me  = used & e.vld & (e.rd == r) & (r != '0);
      mm  = used & m.vld & (m.rd == r) & (r != '0);
      mw  = used & w.vld & (w.rd == r) & (r != '0);
      hz  = (me & (e.tnew > tuse)) | (mm & (m.tnew > tuse)) | (mw & (w.tnew > tuse));
      sel = 2'd0;
      if (me)      sel = (e.tnew == '0) ? 2'd1 : 2'd0;
      else if (mm) sel = (m.tnew == '0) ? 2'd2 : 2'd0;
      else if (mw) sel = (w.tnew == '0) ? 2'd3 : 2'd0;
      return {hz, sel};
   endfunction

   logic [2:0]        rs_res, rt_res;
   logic              issue;
   logic [TNEW_W-1:0] tnew_cap;

   always_comb begin
      rs_res       = resolve(id_rs_used, id_rs, id_rs_tuse, e_slot, m_slot, w_slot);
      rt_res       = resolve(id_rt_used, id_rt, id_rt_tuse, e_slot, m_slot, w_slot);
      stall        = id_valid & (rs_res[2] | rt_res[2]);
      fwd_sel_rs   = rs_res[1:0];
      fwd_sel_rt   = rt_res[1:0];
      cmp_op       = (id_valid & id_is_branch) ? id_cmp_op : 3'b000;
      branch_taken = id_valid & id_is_branch & ~stall & cmp_out;
      issue        = id_valid & ~stall & id_wr_en & (id_rd != '0);
      tnew_cap     = (id_tnew > TNEW_MAX) ? TNEW_MAX : id_tnew;
   end

   // A stalled cycle pushes a bubble into E while M and W keep draining.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         e_slot <= '0;
         m_slot <= '0;
         w_slot <= '0;
      end else begin
         e_slot <= '{vld: issue, rd: id_rd, tnew: tnew_cap};
         m_slot <= '{vld: e_slot.vld, rd: e_slot.rd, tnew: dec_sat(e_slot.tnew)};
         w_slot <= '{vld: m_slot.vld, rd: m_slot.rd, tnew: dec_sat(m_slot.tnew)};
      end
   end

`ifdef HAZARD_STALL_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt  <= '0;
         branch_cnt <= '0;
      end else begin
         if (stall)        stall_cnt  <= stall_cnt + 32'd1;
         if (branch_taken) branch_cnt <= branch_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_id_hazard_sched.sv
// Directed bench for id_hazard_sched: inputs change 1ns after the rising edge, outputs are checked on the falling edge.
module tb_id_hazard_sched;
   logic       clk = 1'b0;
   logic       reset_n;
   logic       id_valid, id_is_branch, id_rs_used, id_rt_used, id_wr_en, cmp_out;
   logic [2:0] id_cmp_op;
   logic [4:0] id_rs, id_rt, id_rd;
   logic [1:0] id_rs_tuse, id_rt_tuse, id_tnew;
   logic       stall, branch_taken;
   logic [1:0] fwd_sel_rs, fwd_sel_rt;
   logic [2:0] cmp_op;
`ifdef HAZARD_STALL_CNT_EN
   logic [31:0] stall_cnt, branch_cnt;
`endif
   int pass = 0;
   int total = 0;

   always #5 clk = ~clk;

   id_hazard_sched dut (
      .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_is_branch(id_is_branch),
      .id_cmp_op(id_cmp_op), .id_rs(id_rs), .id_rt(id_rt), .id_rs_tuse(id_rs_tuse),
      .id_rt_tuse(id_rt_tuse), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
      .id_wr_en(id_wr_en), .id_rd(id_rd), .id_tnew(id_tnew), .cmp_out(cmp_out),
      .stall(stall), .fwd_sel_rs(fwd_sel_rs), .fwd_sel_rt(fwd_sel_rt), .cmp_op(cmp_op),
      .branch_taken(branch_taken)
`ifdef HAZARD_STALL_CNT_EN
      , .stall_cnt(stall_cnt), .branch_cnt(branch_cnt)
`endif
   );

   task automatic set_idle();
      id_valid = 0; id_is_branch = 0; id_cmp_op = 3'b000; id_rs = 0; id_rt = 0;
      id_rs_tuse = 0; id_rt_tuse = 0; id_rs_used = 0; id_rt_used = 0;
      id_wr_en = 0; id_rd = 0; id_tnew = 0; cmp_out = 0;
   endtask

   task automatic set_writer(input logic [4:0] rd, input logic [1:0] tnew);
      set_idle();
      id_valid = 1; id_wr_en = 1; id_rd = rd; id_tnew = tnew;
   endtask

   task automatic set_branch(input logic [4:0] rs, input logic rs_u, input logic [4:0] rt,
                             input logic rt_u, input logic [2:0] op, input logic c);
      set_idle();
      id_valid = 1; id_is_branch = 1; id_rs = rs; id_rs_used = rs_u;
      id_rt = rt; id_rt_used = rt_u; id_cmp_op = op; cmp_out = c;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic flush();
      set_idle();
      repeat (3) cyc();
   endtask

   task automatic test_reset();
      reset_n = 0;
      set_idle();
      @(negedge clk);
      total++; if (stall !== 1'b0) $display("FAIL rst_stall got=%0d exp=0", stall); else pass++;
      total++; if (fwd_sel_rs !== 2'd0) $display("FAIL rst_fwd_rs got=%0d exp=0", fwd_sel_rs); else pass++;
      total++; if (fwd_sel_rt !== 2'd0) $display("FAIL rst_fwd_rt got=%0d exp=0", fwd_sel_rt); else pass++;
      total++; if (branch_taken !== 1'b0) $display("FAIL rst_taken got=%0d exp=0", branch_taken); else pass++;
      total++; if (cmp_op !== 3'b000) $display("FAIL rst_cmp_op got=%0d exp=0", cmp_op); else pass++;
`ifdef HAZARD_STALL_CNT_EN
      total++; if (stall_cnt !== 32'd0) $display("FAIL rst_stall_cnt got=%0d exp=0", stall_cnt); else pass++;
      total++; if (branch_cnt !== 32'd0) $display("FAIL rst_branch_cnt got=%0d exp=0", branch_cnt); else pass++;
`endif
      @(posedge clk);
      #1;
      reset_n = 1;
   endtask

   task automatic test_load_use();
      set_writer(5'd5, 2'd2);
      @(negedge clk);
      total++; if (stall !== 1'b0) $display("FAIL lu_writer_stall got=%0d exp=0", stall); else pass++;
      cyc();
      set_branch(5'd5, 1, 5'd0, 0, 3'b010, 1);
      @(negedge clk);
      total++; if (stall !== 1'b1) $display("FAIL lu_stall_c1 got=%0d exp=1", stall); else pass++;
      total++; if (fwd_sel_rs !== 2'd0) $display("FAIL lu_fwd_c1 got=%0d exp=0", fwd_sel_rs); else pass++;
      total++; if (branch_taken !== 1'b0) $display("FAIL lu_taken_c1 got=%0d exp=0", branch_taken); else pass++;
      cyc();
      @(negedge clk);
      total++; if (stall !== 1'b1) $display("FAIL lu_stall_c2 got=%0d exp=1", stall); else pass++;
      cyc();
      @(negedge clk);
      total++; if (stall !== 1'b0) $display("FAIL lu_stall_c3 got=%0d exp=0", stall); else pass++;
      total++; if (fwd_sel_rs !== 2'd3) $display("FAIL lu_fwd_w got=%0d exp=3", fwd_sel_rs); else pass++;
      total++; if (branch_taken !== 1'b1) $display("FAIL lu_taken got=%0d exp=1", branch_taken); else pass++;
      total++; if (cmp_op !== 3'b010) $display("FAIL lu_cmp_op got=%0d exp=2", cmp_op); else pass++;
`ifdef HAZARD_STALL_CNT_EN
      total++; if (stall_cnt !== 32'd2) $display("FAIL lu_stall_cnt got=%0d exp=2", stall_cnt); else pass++;
`endif
      cyc();
      set_idle();
      @(negedge clk);
`ifdef HAZARD_STALL_CNT_EN
      total++; if (branch_cnt !== 32'd1) $display("FAIL lu_branch_cnt got=%0d exp=1", branch_cnt); else pass++;
`endif
      total++; if (fwd_sel_rs !== 2'd0) $display("FAIL lu_idle_fwd got=%0d exp=0", fwd_sel_rs); else pass++;
      flush();
   endtask

   task automatic test_alu();
      set_writer(5'd8, 2'd1);
      cyc();
      set_branch(5'd0, 0, 5'd8, 1, 3'b001, 0);
      @(negedge clk);
      total++; if (stall !== 1'b1) $display("FAIL alu_stall_c1 got=%0d exp=1", stall); else pass++;
      total++; if (fwd_sel_rt !== 2'd0) $display("FAIL alu_fwd_c1 got=%0d exp=0", fwd_sel_rt); else pass++;
      cyc();
      @(negedge clk);
      total++; if (stall !== 1'b0) $display("FAIL alu_stall_c2 got=%0d exp=0", stall); else pass++;
      total++; if (fwd_sel_rt !== 2'd2) $display("FAIL alu_fwd_m got=%0d exp=2", fwd_sel_rt); else pass++;
      flush();
   endtask

   task automatic test_imm_youngest();
      set_writer(5'd31, 2'd0);
      cyc();
      set_branch(5'd31, 1, 5'd0, 0, 3'b011, 0);
      @(negedge clk);
      total++; if (stall !== 1'b0) $display("FAIL imm_stall got=%0d exp=0", stall); else pass++;
      total++; if (fwd_sel_rs !== 2'd1) $display("FAIL imm_fwd_e got=%0d exp=1", fwd_sel_rs); else pass++;
      flush();
      // Older rd=9 is ready in M but the younger rd=9 in E is not: must stall, not forward M.
      set_writer(5'd9, 2'd0);
      cyc();
      set_writer(5'd9, 2'd1);
      cyc();
      set_branch(5'd9, 1, 5'd9, 1, 3'b001, 1);
      @(negedge clk);
      total++; if (stall !== 1'b1) $display("FAIL yng_stall got=%0d exp=1", stall); else pass++;
      total++; if (fwd_sel_rs !== 2'd0) $display("FAIL yng_fwd_rs_c1 got=%0d exp=0", fwd_sel_rs); else pass++;
      cyc();
      @(negedge clk);
      total++; if (stall !== 1'b0) $display("FAIL yng_stall_c2 got=%0d exp=0", stall); else pass++;
      total++; if (fwd_sel_rs !== 2'd2) $display("FAIL yng_fwd_rs got=%0d exp=2", fwd_sel_rs); else pass++;
      total++; if (fwd_sel_rt !== 2'd2) $display("FAIL yng_fwd_rt got=%0d exp=2", fwd_sel_rt); else pass++;
      flush();
      set_writer(5'd9, 2'd0);
      cyc();
      set_writer(5'd9, 2'd0);
      cyc();
      set_branch(5'd9, 1, 5'd0, 0, 3'b001, 0);
      @(negedge clk);
      total++; if (fwd_sel_rs !== 2'd1) $display("FAIL yng_both_ready got=%0d exp=1", fwd_sel_rs); else pass++;
      flush();
      // tnew=3 saturates to 2, so exactly two stall cycles.
      set_writer(5'd12, 2'd3);
      cyc();
      set_branch(5'd12, 1, 5'd0, 0, 3'b001, 0);
      @(negedge clk);
      total++; if (stall !== 1'b1) $display("FAIL sat_stall_c1 got=%0d exp=1", stall); else pass++;
      cyc(); cyc();
      @(negedge clk);
      total++; if (stall !== 1'b0) $display("FAIL sat_stall_c3 got=%0d exp=0", stall); else pass++;
      total++; if (fwd_sel_rs !== 2'd3) $display("FAIL sat_fwd got=%0d exp=3", fwd_sel_rs); else pass++;
      flush();
   endtask

   task automatic test_r0_unused();
      set_writer(5'd0, 2'd2);
      cyc();
      set_branch(5'd0, 1, 5'd0, 1, 3'b001, 0);
      @(negedge clk);
      total++; if (stall !== 1'b0) $display("FAIL r0_stall got=%0d exp=0", stall); else pass++;
      total++; if (fwd_sel_rs !== 2'd0) $display("FAIL r0_fwd got=%0d exp=0", fwd_sel_rs); else pass++;
      flush();
      set_writer(5'd6, 2'd2);
      cyc();
      set_branch(5'd0, 0, 5'd6, 0, 3'b001, 0);
      @(negedge clk);
      total++; if (stall !== 1'b0) $display("FAIL unused_stall got=%0d exp=0", stall); else pass++;
      total++; if (fwd_sel_rt !== 2'd0) $display("FAIL unused_fwd got=%0d exp=0", fwd_sel_rt); else pass++;
      id_rt_used = 1;
      id_valid = 0;
      #1;
      total++; if (stall !== 1'b0) $display("FAIL novalid_stall got=%0d exp=0", stall); else pass++;
      id_valid = 1;
      #1;
      total++; if (stall !== 1'b1) $display("FAIL used_stall got=%0d exp=1", stall); else pass++;
      flush();
   endtask

   task automatic test_branch_gating();
      set_branch(5'd1, 1, 5'd2, 1, 3'b000, 1);
      @(negedge clk);
      total++; if (branch_taken !== 1'b1) $display("FAIL bg_taken got=%0d exp=1", branch_taken); else pass++;
      total++; if (cmp_op !== 3'b000) $display("FAIL bg_cmp_op got=%0d exp=0", cmp_op); else pass++;
      id_cmp_op = 3'b101;
      cmp_out = 0;
      #1;
      total++; if (cmp_op !== 3'b101) $display("FAIL bg_cmp_op5 got=%0d exp=5", cmp_op); else pass++;
      total++; if (branch_taken !== 1'b0) $display("FAIL bg_nottaken got=%0d exp=0", branch_taken); else pass++;
      id_is_branch = 0;
      cmp_out = 1;
      #1;
      total++; if (cmp_op !== 3'b000) $display("FAIL bg_nonbr_op got=%0d exp=0", cmp_op); else pass++;
      total++; if (branch_taken !== 1'b0) $display("FAIL bg_nonbr_taken got=%0d exp=0", branch_taken); else pass++;
      cyc();
      set_writer(5'd3, 2'd1);
      cyc();
      set_branch(5'd3, 1, 5'd0, 0, 3'b000, 1);
      @(negedge clk);
      total++; if (stall !== 1'b1) $display("FAIL bg_stall got=%0d exp=1", stall); else pass++;
      total++; if (branch_taken !== 1'b0) $display("FAIL bg_stall_taken got=%0d exp=0", branch_taken); else pass++;
      flush();
   endtask

   task automatic test_reset_mid();
      set_writer(5'd10, 2'd2);
      cyc();
      set_writer(5'd11, 2'd2);
      cyc();
      set_writer(5'd12, 2'd2);
      cyc();
      set_branch(5'd12, 1, 5'd11, 1, 3'b001, 1);
      #1;
      total++; if (stall !== 1'b1) $display("FAIL rm_pre_stall got=%0d exp=1", stall); else pass++;
      reset_n = 0;
      #1;
      total++; if (stall !== 1'b0) $display("FAIL rm_async_stall got=%0d exp=0", stall); else pass++;
      total++; if (branch_taken !== 1'b1) $display("FAIL rm_async_taken got=%0d exp=1", branch_taken); else pass++;
`ifdef HAZARD_STALL_CNT_EN
      total++; if (stall_cnt !== 32'd0) $display("FAIL rm_stall_cnt got=%0d exp=0", stall_cnt); else pass++;
`endif
      #4;
      reset_n = 1;
      @(negedge clk);
      total++; if (stall !== 1'b0) $display("FAIL rm_post_stall got=%0d exp=0", stall); else pass++;
      total++; if (fwd_sel_rs !== 2'd0) $display("FAIL rm_post_fwd got=%0d exp=0", fwd_sel_rs); else pass++;
`ifdef HAZARD_STALL_CNT_EN
      total++; if (stall_cnt !== 32'd0) $display("FAIL rm_post_cnt got=%0d exp=0", stall_cnt); else pass++;
`endif
      flush();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_alu();
      test_imm_youngest();
      test_r0_unused();
      test_branch_gating();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule

// File: doc/id_hazard_sched.md
Name: id_hazard_sched

Overview:
- Scoreboard-based hazard scheduler for the ID-stage branch comparator in the 5-stage pipeline (ID→E→M→W).
- Tracks in-flight register writers and decides per cycle whether the ID instruction stalls.
- Drives the forwarding selects for the comparator's two operands and passes the compare op through.
- Qualifies the comparator result into a branch-taken strobe for the PC mux.

Parameters:
- REG_AW, 5, register index width (32 GPRs; index 0 never tracked)
- TNEW_W, 2, width of ready-countdown field (tnew range 0..2)

Ports:
- clk  in  1  pipeline clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a valid instruction
- id_is_branch  in  1  ID instruction is a compare-branch
- id_cmp_op  in  3  compare op requested by the ID instruction
- id_rs  in  5  source register A
- id_rt  in  5  source register B
- id_rs_tuse  in  2  cycles until rs value is consumed (0 = in ID)
- id_rt_tuse  in  2  same for rt
- id_rs_used  in  1  rs is a real source
- id_rt_used  in  1  rt is a real source
- id_wr_en  in  1  ID instruction writes a register
- id_rd  in  5  destination register
- id_tnew  in  2  cycles after entering E until its result is forwardable
- cmp_out  in  1  comparator result for the current ID operands
- stall  out  1  hold PC/IF-ID, insert bubble into E
- fwd_sel_rs  out  2  0=RF, 1=E, 2=M, 3=W
- fwd_sel_rt  out  2  same encoding
- cmp_op  out  3  to comparator
- branch_taken  out  1  redirect PC to branch target this cycle

Behaviour:
- Scoreboard: three slots E, M, W, each {valid, rd, tnew}. Reset (async, reset_n=0) clears all valid bits. All outputs are combinational from the scoreboard and ID inputs, so they read 0 during reset.
- Each rising edge, all slots shift together:
  - W←M, with tnew = sat0(M.tnew−1).
  - M←E, with tnew = sat0(E.tnew−1).
  - E←{issue, id_rd, id_tnew}.
  - issue = id_valid & ~stall & id_wr_en & (id_rd≠0).
  - A stalled cycle loads a bubble into E (valid=0). M and W still advance.
- Match rule: operand X matches slot S if id_X_used & S.valid & (S.rd==id_X) & (id_X≠0).
- Stall: stall = id_valid & OR over operands and slots of (match & S.tnew > id_X_tuse).
- Forwarding:
  - fwd_sel_X is the youngest matching slot (priority E>M>W) with tnew==0.
  - If the youngest match has tnew>0, fwd_sel_X is 0 and stall covers the hazard.
  - If there is no match, fwd_sel_X is 0.
- Compare op: cmp_op = id_cmp_op when id_valid & id_is_branch, else 3'b000.
- Branch strobe:
  - branch_taken = id_valid & id_is_branch & ~stall & cmp_out.
  - It never asserts in a stall cycle.
  - There is no delay-slot annul.
- Simultaneous events:
  - A slot leaving W and a new issue into E in the same edge are independent.
  - Multiple slots matching the same rd are resolved by youngest priority.
- id_tnew values above 2 saturate to 2 on capture.
- Reset asserted mid-stall clears the scoreboard immediately. The first cycle after release has stall=0 unless ID has an r0-free hazard, which cannot exist with an empty board.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt [31:0], a counter incremented on each clk edge where stall=1.
  - Reset to 0 by reset_n; wraps at 0xFFFFFFFF→0.
  - Adds output branch_cnt [31:0], counting branch_taken cycles with the same reset and wrap rules.
- When undefined: neither port nor counter exists, and the remaining behaviour is identical.

Test Plan:
- Load-use on branch: issue writer rd=5 with tnew=2, next cycle branch rs=5 with tuse=0 → stall=1 for 2 cycles, then fwd_sel_rs=3 (W), stall=0, branch_taken follows cmp_out.
- ALU producer: issue rd=8 with tnew=1, next cycle branch rt=8 → stall=1 for 1 cycle, then fwd_sel_rt=2 (M).
- Immediate producer: issue rd=31 with tnew=0, next cycle branch rs=31 → stall=0, fwd_sel_rs=1 (E); two consecutive writers to rd=9 → youngest slot selected.
- r0 and unused operands: writer rd=0 tnew=2, then branch rs=0 → stall=0, fwd_sel_rs=0; id_rt_used=0 with a matching rt → no stall.
- Branch gating: id_is_branch=1, cmp_op=000, cmp_out=1, no hazards → branch_taken=1, cmp_op=000; the same case while stalled → branch_taken=0.
- Reset mid-operation: board full of tnew=2 writers, pulse reset_n low for half a cycle → stall drops immediately and stays 0 for a hazard-free ID; with HAZARD_STALL_CNT_EN defined, stall_cnt=0 after reset and counts 2 for the load-use case.
